// File: rtl/datapath_hs.sv
// Processor datapath: IR/MDR, register file, PC and PSR, operand muxes, and a
// three-state memory handshake FSM. The ALU itself sits outside this block.
module datapath_hs #(
  parameter int WIDTH            = 16,
  parameter int REG_BITS         = 4,
  parameter int OP_CODE_BITS     = 4,
  parameter int EXT_OP_CODE_BITS = 4,
  parameter int IMM_BITS         = 8,
  parameter int ZERO_REG0        = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reg_write,
  input  logic                        alu_A_src,
  input  logic                        alu_B_src,
  input  logic                        pc_en,
  input  logic                        instruction_en,
  input  logic                        psr_en,
  input  logic                        imm_sign_ext,
  input  logic [1:0]                  pc_src,
  input  logic [1:0]                  reg_write_src,
  input  logic                        mem_start,
  input  logic [1:0]                  mem_op,
  input  logic                        mem_ready,
  input  logic [WIDTH-1:0]            data_from_mem,
  input  logic [WIDTH-1:0]            alu_out,
  input  logic [WIDTH-1:0]            alu_flags,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [WIDTH-1:0]            mem_address,
  output logic [WIDTH-1:0]            data_to_mem_store,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic                        mem_busy,
  output logic                        mem_done,
  output logic [OP_CODE_BITS-1:0]     op_code,
  output logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  output logic [REG_BITS-1:0]         A_index,
  output logic [REG_BITS-1:0]         B_index,
  output logic [WIDTH-1:0]            psr,
  output logic [WIDTH-1:0]            pc
);

  localparam int NREG = 1 << REG_BITS;
  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} mem_state_e;

  logic [WIDTH-1:0] pc_q, pc_d, ir_q, mdr_q, psr_q, reg_a_q, reg_b_q;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rd_a, rd_b, imm, wdata, pc_plus1;
  logic             a_is_zero, b_is_zero, rf_we, capture;

  mem_state_e       state_q;
  logic [1:0]       mop_q;
  logic [WIDTH-1:0] maddr_q, mdata_q;
  logic             req_q, we_q, busy_q, done_q;

  assign op_code     = ir_q[WIDTH-1 -: OP_CODE_BITS];
  assign A_index     = ir_q[WIDTH-OP_CODE_BITS-1 -: REG_BITS];
  assign ext_op_code = ir_q[4+EXT_OP_CODE_BITS-1:4];
  assign B_index     = ir_q[REG_BITS-1:0];

  assign imm = imm_sign_ext ? {{(WIDTH-IMM_BITS){ir_q[IMM_BITS-1]}}, ir_q[IMM_BITS-1:0]}
                            : {{(WIDTH-IMM_BITS){1'b0}}, ir_q[IMM_BITS-1:0]};

  assign a_is_zero = (ZERO_REG0 != 0) && (A_index == '0);
  assign b_is_zero = (ZERO_REG0 != 0) && (B_index == '0);
  assign rd_a      = a_is_zero ? '0 : rf_q[A_index];
  assign rd_b      = b_is_zero ? '0 : rf_q[B_index];
  assign rf_we     = reg_write && !a_is_zero;

  assign pc_plus1 = pc_q + WIDTH'(1);
  assign alu_a    = alu_A_src ? reg_a_q : pc_q;
  assign alu_b    = alu_B_src ? imm : reg_b_q;
  assign pc       = pc_q;
  assign psr      = psr_q;

  always_comb begin
    wdata = '0;
    case (reg_write_src)
      2'd0:    wdata = alu_out;
      2'd1:    wdata = mdr_q;
      2'd2:    wdata = pc_plus1;
      default: wdata = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      case (pc_src)
        2'd0:    pc_d = alu_out;
        2'd1:    pc_d = reg_b_q;
        2'd2:    pc_d = pc_plus1;
        default: pc_d = pc_q;
      endcase
    end
  end

  assign capture = (state_q == S_REQ) && mem_ready;

  // reg_A/reg_B sample the old array contents, so a same-edge write is not seen
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      psr_q   <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      reg_a_q <= rd_a;
      reg_b_q <= rd_b;
      if (psr_en) psr_q <= alu_flags;
      if (rf_we) rf_q[A_index] <= wdata;
      if (capture && mop_q == OP_FETCH && instruction_en) ir_q <= data_from_mem;
      if (capture && mop_q == OP_LOAD) mdr_q <= data_from_mem;
    end
  end

  // Memory FSM; starts while busy are dropped rather than queued
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mop_q   <= OP_FETCH;
      maddr_q <= '0;
      mdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_start && mem_op != OP_RSVD) begin
            state_q <= S_REQ;
            mop_q   <= mem_op;
            maddr_q <= (mem_op == OP_FETCH) ? pc_q : reg_b_q;
            mdata_q <= (mem_op == OP_STORE) ? reg_a_q : '0;
            req_q   <= 1'b1;
            we_q    <= (mem_op == OP_STORE);
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req           = req_q;
  assign mem_we            = we_q;
  assign mem_busy          = busy_q;
  assign mem_done          = done_q;
  assign mem_address       = req_q ? maddr_q : pc_q;
  assign data_to_mem_store = req_q ? mdata_q : '0;

endmodule

// File: tb/tb_datapath_hs.sv
// Scoreboard bench for datapath_hs: stimulus pushes expected memory accesses,
// a negedge monitor checks every request cycle and completion against them.
module tb_datapath_hs;

  logic        clk, reset;
  logic        reg_write, alu_A_src, alu_B_src, pc_en, instruction_en, psr_en, imm_sign_ext;
  logic [1:0]  pc_src, reg_write_src, mem_op;
  logic        mem_start, mem_ready;
  logic [15:0] data_from_mem, alu_out, alu_flags;
  logic [15:0] alu_a, alu_b, mem_address, data_to_mem_store, psr, pc;
  logic        mem_req, mem_we, mem_busy, mem_done;
  logic [3:0]  op_code, ext_op_code, A_index, B_index;

  datapath_hs dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .alu_A_src(alu_A_src),
    .alu_B_src(alu_B_src), .pc_en(pc_en), .instruction_en(instruction_en),
    .psr_en(psr_en), .imm_sign_ext(imm_sign_ext), .pc_src(pc_src),
    .reg_write_src(reg_write_src), .mem_start(mem_start), .mem_op(mem_op),
    .mem_ready(mem_ready), .data_from_mem(data_from_mem), .alu_out(alu_out),
    .alu_flags(alu_flags), .alu_a(alu_a), .alu_b(alu_b), .mem_address(mem_address),
    .data_to_mem_store(data_to_mem_store), .mem_req(mem_req), .mem_we(mem_we),
    .mem_busy(mem_busy), .mem_done(mem_done), .op_code(op_code),
    .ext_op_code(ext_op_code), .A_index(A_index), .B_index(B_index),
    .psr(psr), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: architectural state only
  logic [15:0] m_pc, m_ir, m_mdr, m_psr;
  logic [15:0] m_regs [16];

  function automatic logic [3:0] aidx(); return m_ir[11:8]; endfunction
  function automatic logic [3:0] bidx(); return m_ir[3:0]; endfunction
  function automatic logic [15:0] rd(input logic [3:0] i);
    return (i == 4'd0) ? 16'h0 : m_regs[i];
  endfunction
  function automatic logic [15:0] imm_m(input logic sx);
    return sx ? 16'($signed(m_ir[7:0])) : {8'h00, m_ir[7:0]};
  endfunction
  function automatic void model_reset();
    m_pc = 0; m_ir = 0; m_mdr = 0; m_psr = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] exp_ir;
    int          reqs;
  } acc_t;
  acc_t sb[$];
  int   req_seen = 0;

  always @(negedge clk) begin
    if (!mem_busy) req_seen = 0;
    if (mem_req) begin
      if (sb.size() == 0) chk("spurious_req", {31'h0, mem_req}, 32'h0);
      else begin
        req_seen++;
        chk("req_addr", mem_address, sb[0].addr);
        chk("req_we", mem_we, sb[0].we);
        if (sb[0].we) chk("req_store_data", data_to_mem_store, sb[0].wdata);
        chk("req_busy", mem_busy, 1);
      end
    end
    if (mem_done) begin
      if (sb.size() == 0) chk("spurious_done", {31'h0, mem_done}, 32'h0);
      else begin
        chk("done_ir", {op_code, A_index, ext_op_code, B_index}, sb[0].exp_ir);
        chk("req_cycles", req_seen, sb[0].reqs);
        chk("done_busy", mem_busy, 1);
        void'(sb.pop_front());
      end
      req_seen = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // one idle cycle, then compare every observable against the model
  task automatic check_state();
    mem_ready = 1'($urandom_range(0, 1));
    alu_out   = 16'($urandom);
    step();
    mem_ready = 0;
    @(negedge clk);
    alu_A_src = 1; alu_B_src = 0; #1;
    chk("reg_a", alu_a, rd(aidx()));
    chk("reg_b", alu_b, rd(bidx()));
    alu_A_src = 0; alu_B_src = 1; imm_sign_ext = 1'($urandom_range(0, 1)); #1;
    chk("alu_a_pc", alu_a, m_pc);
    chk("imm", alu_b, imm_m(imm_sign_ext));
    chk("pc", pc, m_pc);
    chk("ir", {op_code, A_index, ext_op_code, B_index}, m_ir);
    chk("psr", psr, m_psr);
    chk("idle_addr", mem_address, m_pc);
    chk("idle_store_data", data_to_mem_store, 0);
    chk("idle_flags", {mem_req, mem_we, mem_busy, mem_done}, 0);
    alu_B_src = 0;
  endtask

  task automatic access(input logic [1:0] op, input logic [15:0] rdata, input int waits,
                        input logic ien, input logic busy_start);
    acc_t e;
    e.addr   = (op == 2'b00) ? m_pc : rd(bidx());
    e.we     = (op == 2'b10);
    e.wdata  = (op == 2'b10) ? rd(aidx()) : 16'h0;
    e.exp_ir = (op == 2'b00 && ien) ? rdata : m_ir;
    e.reqs   = waits + 1;
    sb.push_back(e);
    mem_start = 1; mem_op = op;
    step();
    for (int w = 0; w < waits; w++) begin
      mem_start = busy_start | 1'($urandom_range(0, 1));
      mem_op    = 2'($urandom);
      step();
    end
    mem_ready = 1; data_from_mem = rdata; instruction_en = ien; mem_start = busy_start;
    step();
    mem_ready = 1'($urandom_range(0, 1)); instruction_en = 1'($urandom_range(0, 1));
    data_from_mem = 16'($urandom);
    step();
    mem_ready = 0; mem_start = 0; instruction_en = 0;
    if (op == 2'b00 && ien) m_ir = rdata;
    if (op == 2'b01) m_mdr = rdata;
    check_state();
  endtask

  task automatic set_ir(input logic [15:0] v);
    access(2'b00, v, $urandom_range(0, 2), 1'b1, 1'b0);
  endtask

  task automatic wreg(input logic [1:0] src, input logic [15:0] val);
    logic [15:0] old, wd;
    old = rd(aidx());
    case (src)
      2'd0:    wd = val;
      2'd1:    wd = m_mdr;
      2'd2:    wd = m_pc + 16'd1;
      default: wd = 16'h0;
    endcase
    reg_write = 1; reg_write_src = src; alu_out = val; alu_A_src = 1;
    step();
    reg_write = 0; reg_write_src = 0;
    @(negedge clk);
    chk("prewrite_capture", alu_a, old);
    alu_A_src = 0;
    if (aidx() != 4'd0) m_regs[aidx()] = wd;
    check_state();
  endtask

  task automatic pc_op(input logic [1:0] src, input logic en, input logic [15:0] val);
    pc_src = src; pc_en = en; alu_out = val;
    step();
    pc_en = 0; pc_src = 0;
    if (en) begin
      case (src)
        2'd0:    m_pc = val;
        2'd1:    m_pc = rd(bidx());
        2'd2:    m_pc = m_pc + 16'd1;
        default: m_pc = m_pc;
      endcase
    end
    check_state();
  endtask

  task automatic psr_op(input logic en, input logic [15:0] v);
    psr_en = en; alu_flags = v;
    step();
    psr_en = 0;
    if (en) m_psr = v;
    check_state();
  endtask

  task automatic bad_start();
    mem_start = 1; mem_op = 2'b11;
    step();
    mem_start = 0;
    @(negedge clk);
    chk("rsvd_ignored", {mem_req, mem_busy, mem_done}, 0);
    check_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; reg_write = 0; alu_A_src = 0; alu_B_src = 0; pc_en = 0;
    instruction_en = 0; psr_en = 0; imm_sign_ext = 0; pc_src = 0; reg_write_src = 0;
    mem_start = 0; mem_op = 0; mem_ready = 0; data_from_mem = 0; alu_out = 0; alu_flags = 0;
    model_reset();
    step(); step();
    reset = 0;
    check_state();

    // reset while a fetch is pending discards it
    sb.push_back('{addr: 16'h0, we: 1'b0, wdata: 16'h0, exp_ir: 16'hDEAD, reqs: 2});
    mem_start = 1; mem_op = 2'b00; step();
    mem_start = 0; step();
    mem_ready = 1; data_from_mem = 16'hDEAD; instruction_en = 1; reset = 1;
    step();
    reset = 0; mem_ready = 0; instruction_en = 0;
    sb.delete();
    model_reset();
    @(negedge clk);
    chk("rst_req_drop", {mem_req, mem_done}, 0);
    check_state();
    chk("rst_ir_kept_zero", {op_code, A_index, ext_op_code, B_index}, 16'h0);

    bad_start();

    // fetch with three wait cycles
    pc_op(2'd0, 1'b1, 16'h0010);
    access(2'b00, 16'h5A73, 3, 1'b1, 1'b0);
    chk("dec_op", op_code, 4'h5);
    chk("dec_a", A_index, 4'hA);
    chk("dec_ext", ext_op_code, 4'h7);
    chk("dec_b", B_index, 4'h3);

    // load then write-back into r2
    set_ir(16'h0505);
    wreg(2'd0, 16'h0100);
    access(2'b01, 16'hBEEF, $urandom_range(0, 3), 1'b0, 1'b0);
    set_ir(16'h0205);
    wreg(2'd1, 16'h0000);
    alu_A_src = 1; #1;
    chk("load_writeback_r2", alu_a, 16'hBEEF);
    alu_A_src = 0;

    // store with starts hammered during the access
    set_ir(16'h0404);
    wreg(2'd0, 16'h0200);
    set_ir(16'h0304);
    wreg(2'd0, 16'h1234);
    access(2'b10, 16'h0000, 2, 1'b0, 1'b1);

    // pc wrap and hold
    pc_op(2'd0, 1'b1, 16'hFFFF);
    pc_op(2'd2, 1'b1, 16'h0000);
    chk("pc_wrap", pc, 16'h0000);
    pc_op(2'd0, 1'b1, 16'h4321);
    pc_op(2'd3, 1'b1, 16'h9999);
    chk("pc_hold_src3", pc, 16'h4321);
    for (int s = 0; s < 4; s++) pc_op(2'(s), 1'b0, 16'h7777);
    chk("pc_hold_en0", pc, 16'h4321);

    // immediate extension and r0
    set_ir(16'h0080);
    @(negedge clk);
    alu_B_src = 1; imm_sign_ext = 1; #1;
    chk("imm_sext", alu_b, 16'hFF80);
    imm_sign_ext = 0; #1;
    chk("imm_zext", alu_b, 16'h0080);
    alu_B_src = 0;
    wreg(2'd0, 16'h1111);
    alu_A_src = 1; #1;
    chk("r0_zero", alu_a, 16'h0000);
    alu_A_src = 0;

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 6))
        0: access(2'b00, 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        1: access(2'b01, 16'($urandom), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
        2: access(2'b10, 16'($urandom), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
        3: wreg(2'($urandom), 16'($urandom));
        4: pc_op(2'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
        5: psr_op(1'($urandom_range(0, 1)), 16'($urandom));
        default: bad_start();
      endcase
    end

    step();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
